// File: rtl/bcd9_digit_decoder.sv
// -----------------------------------------------------------------------------
// bcd9_digit_decoder
//
// Accepts a word of NDIG nine's-complement BCD digits, most-significant digit
// first, one digit per in_valid/in_ready handshake. Each digit is restored
// (r = 9 - d) and folded into a binary accumulator (acc = acc*10 + r). When the
// last digit of a word is taken, the binary value and a sticky "non-BCD digit
// seen" flag are registered and offered on a valid/ready output. The block
// does not take new digits while a result is being held.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous abort; discards the partial or pending word
//   in_valid   : in_digit is presented
//   in_digit   : 4-bit nine's-complement BCD digit, MSD first
//   in_ready   : block can accept a digit (high while accumulating)
//   out_valid  : out_value / out_err hold a completed word
//   out_ready  : consumer takes the result
//   out_value  : decoded binary value (OUTW bits, truncated)
//   out_err    : at least one digit of the word was greater than 9
// -----------------------------------------------------------------------------
module bcd9_digit_decoder #(
  parameter int NDIG = 4,
  parameter int OUTW = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [3:0]      in_digit,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUTW-1:0] out_value,
  output logic            out_err
);

  // A one-digit word still needs a 1-bit counter to keep the vectors legal.
  localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NDIG - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Undo the nine's complement; non-BCD codes contribute nothing.
  function automatic logic [3:0] restore_digit(input logic [3:0] d);
    logic [3:0] r;
    if (d <= 4'd9) begin
      r = 4'd9 - d;
    end else begin
      r = 4'd0;
    end
    return r;
  endfunction

  function automatic logic digit_is_bad(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [OUTW-1:0]   acc_q, acc_d;
  logic              err_q, err_d;
  logic [OUTW-1:0]   out_value_q, out_value_d;
  logic              out_err_q, out_err_d;

  logic [3:0]        digit_r_s;
  logic              digit_bad_s;
  logic [OUTW-1:0]   mac_s;

  // Restored digit and the multiply-accumulate candidate for this cycle.
  always_comb begin
    digit_r_s   = restore_digit(in_digit);
    digit_bad_s = digit_is_bad(in_digit);
    // acc*10 as (acc<<3)+(acc<<1); everything wraps at OUTW bits.
    mac_s = (acc_q << 3) + (acc_q << 1) + OUTW'(digit_r_s);
  end

  // Next-state logic: clr overrides both digit accept and result consume.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_d       = err_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;

    if (clr) begin
      state_d = ACCUM;
      cnt_d   = '0;
      acc_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_d = mac_s;
            err_d = err_q | digit_bad_s;
            if (cnt_q == CNT_LAST) begin
              out_value_d = mac_s;
              out_err_d   = err_q | digit_bad_s;
              state_d     = HOLD;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end else begin
            state_d = ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = ACCUM;
          cnt_d   = '0;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
    end
  end

  // Handshake flags come straight from the state flop, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_value = out_value_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd9_digit_decoder.sv
module tb_bcd9_digit_decoder;

  localparam int OUTW = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic [3:0]      in_digit = 4'd0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [OUTW-1:0] out_value;
  logic            out_err;

  int checks = 0;
  int errors = 0;

  // expected {err, value}
  logic [OUTW:0] exp_q[$];

  bcd9_digit_decoder #(.NDIG(4), .OUTW(OUTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_digit  (in_digit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the next rising edge when out_valid and
  // out_ready are both high and no clr is pending.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clr) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", int'(out_value), -1);
      end else begin
        logic [OUTW:0] e;
        e = exp_q.pop_front();
        chk("sb_value", int'(out_value), int'(e[OUTW-1:0]));
        chk("sb_err", int'(out_err), int'(e[OUTW]));
      end
    end
  end

  // Present one digit and return #1 after the edge that took it.
  task automatic send_digit(input logic [3:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_digit = d;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3,
                           input int exp_val, input logic exp_err);
    exp_q.push_back({exp_err, OUTW'(exp_val)});
    send_digit(d0);
    send_digit(d1);
    send_digit(d2);
    send_digit(d3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_value", int'(out_value), 0);
    chk("rst_out_err", int'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready_first", int'(in_ready), 1);

    // Basic decode with latency check
    exp_q.push_back({1'b0, OUTW'(123)});
    send_digit(4'd9);
    send_digit(4'd8);
    send_digit(4'd7);
    chk("basic_valid_before_last", int'(out_valid), 0);
    send_digit(4'd6);
    chk("basic_latency_valid", int'(out_valid), 1);
    chk("basic_in_ready_hold", int'(in_ready), 0);
    chk("basic_value", int'(out_value), 123);
    idle(1);
    chk("basic_in_ready_after", int'(in_ready), 1);

    // Maximum / minimum
    send_word(4'd0, 4'd0, 4'd0, 4'd0, 9999, 1'b0);
    idle(1);
    send_word(4'd9, 4'd9, 4'd9, 4'd9, 0, 1'b0);
    idle(1);

    // Non-BCD digit, then a clean word
    send_word(4'd9, 4'hA, 4'd7, 4'd6, 23, 1'b1);
    chk("nonbcd_err", int'(out_err), 1);
    idle(1);
    send_word(4'd1, 4'd2, 4'd3, 4'd4, 8765, 1'b0);
    chk("clean_err", int'(out_err), 0);
    idle(1);

    // Backpressure
    out_ready = 1'b0;
    send_word(4'd9, 4'd8, 4'd7, 4'd6, 123, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_value", int'(out_value), 123);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("bp_in_ready_same_cycle", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("bp_in_ready_next", int'(in_ready), 1);
    chk("bp_valid_drop", int'(out_valid), 0);

    // Abort after two digits
    send_digit(4'd3);
    send_digit(4'd3);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    send_word(4'd8, 4'd7, 4'd6, 4'd5, 1234, 1'b0);
    idle(1);

    // clr together with the fourth digit: no output, last result retained
    send_digit(4'd1);
    send_digit(4'd1);
    send_digit(4'd1);
    clr = 1'b1;
    in_valid = 1'b1;
    in_digit = 4'd1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr4_no_valid", int'(out_valid), 0);
    chk("clr4_in_ready", int'(in_ready), 1);
    idle(2);
    chk("clr4_no_valid_later", int'(out_valid), 0);
    chk("clr4_value_held", int'(out_value), 1234);
    send_word(4'd0, 4'd0, 4'd0, 4'd0, 9999, 1'b0);
    idle(1);
    // Framing check: a bad word leaves out_err set before the reset test
    send_word(4'hF, 4'd0, 4'd0, 4'd0, 999, 1'b1);
    idle(1);

    // Reset mid-word
    send_digit(4'd2);
    send_digit(4'd2);
    send_digit(4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_value", int'(out_value), 0);
    chk("rstmid_out_err", int'(out_err), 0);
    chk("rstmid_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_in_ready", int'(in_ready), 1);
    chk("rstmid_no_valid", int'(out_valid), 0);
    send_word(4'd9, 4'd8, 4'd7, 4'd6, 123, 1'b0);
    idle(3);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
